// File: rtl/day04_result_uart.sv
`default_nettype none
// ============================================================================
// Module      : day04_result_uart
// Description : Reporting stage for the day-04 solver core. On the rising
//               edge of `done` it captures both 64-bit results and converts
//               each to unsigned decimal ASCII with a bit-serial
//               double-dabble. The text "<part1>\n<part2>\n" is then sent
//               on an 8N1 UART line.
//
// Parameters  : CLKS_PER_BIT - clock cycles per UART bit (minimum 2)
// Ports       : clk           - system clock, rising edge
//               rst           - synchronous active-high reset
//               part1_result  - 64-bit part 1 answer
//               part2_result  - 64-bit part 2 answer
//               done          - core completion level; a rising edge starts a report
//               uart_tx       - serial output, idle high
//               busy          - high from capture until the report is finished
//               report_done   - sticky, high once the full report has been sent
// Options     : `define REPORT_LABEL_EN to prefix each line with "P1=" / "P2="
// Revision    : 1.0 - initial release
// ============================================================================
module day04_result_uart #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] part1_result,
    input  logic [63:0] part2_result,
    input  logic        done,
    output logic        uart_tx,
    output logic        busy,
    output logic        report_done
);

    localparam int                   C_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [C_CNT_W-1:0]   C_BAUD_LAST = C_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CONV = 3'd1;
    localparam logic [2:0] S_EMIT = 3'd2;
    localparam logic [2:0] S_TX   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    // Emit phase: which kind of byte S_EMIT produces next.
`ifdef REPORT_LABEL_EN
    localparam logic [1:0] PH_LABEL = 2'd0;
`endif
    localparam logic [1:0] PH_DIGIT = 2'd1;
    localparam logic [1:0] PH_NL    = 2'd2;

`ifdef REPORT_LABEL_EN
    localparam logic [1:0] C_PH_START = PH_LABEL;
`else
    localparam logic [1:0] C_PH_START = PH_DIGIT;
`endif

    logic [2:0]         state_q, state_d;
    logic               done_q, done_d;
    logic [63:0]        p2_q, p2_d;
    logic               sel_q, sel_d;
    logic [63:0]        bin_q, bin_d;
    logic [79:0]        bcd_q, bcd_d;
    logic [5:0]         iter_q, iter_d;
    logic [1:0]         ph_q, ph_d;
    logic               first_q, first_d;
    logic [4:0]         dig_q, dig_d;
    logic [7:0]         byte_q, byte_d;
    logic [3:0]         bit_q, bit_d;
    logic [C_CNT_W-1:0] baud_q, baud_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               rdone_q, rdone_d;
`ifdef REPORT_LABEL_EN
    logic [1:0]         lbl_q, lbl_d;
`endif

    logic [79:0] w_bcd_adj;
    logic [4:0]  w_msd;
    logic [4:0]  w_pos;
    logic [3:0]  w_digit;
    logic        w_trigger;

    // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
    always_comb begin
        w_bcd_adj = bcd_q;
        for (int i = 0; i < 20; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Position of the most significant non-zero digit; 0 when the value is
    // zero, so a zero result still prints a single "0".
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < 20; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                w_msd = 5'(i);
            end
        end
    end

    assign w_pos     = first_q ? w_msd : dig_q;
    assign w_digit   = bcd_q[{w_pos, 2'b00} +: 4];
    assign w_trigger = done & ~done_q & (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        done_d  = done;
        p2_d    = p2_q;
        sel_d   = sel_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        ph_d    = ph_q;
        first_d = first_q;
        dig_d   = dig_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        rdone_d = rdone_q;
`ifdef REPORT_LABEL_EN
        lbl_d   = lbl_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (w_trigger) begin
                    // part1 goes straight into the converter; part2 is held
                    // so later input changes cannot leak into the report.
                    bin_d   = part1_result;
                    p2_d    = part2_result;
                    bcd_d   = '0;
                    iter_d  = '0;
                    sel_d   = 1'b0;
                    busy_d  = 1'b1;
                    rdone_d = 1'b0;
                    state_d = S_CONV;
                end
            end

            S_CONV: begin
                bcd_d  = {w_bcd_adj[78:0], bin_q[63]};
                bin_d  = {bin_q[62:0], 1'b0};
                iter_d = iter_q + 6'd1;
                if (iter_q == 6'd63) begin
                    ph_d    = C_PH_START;
                    first_d = 1'b1;
`ifdef REPORT_LABEL_EN
                    lbl_d   = 2'd0;
`endif
                    state_d = S_EMIT;
                end
            end

            S_EMIT: begin
                case (ph_q)
`ifdef REPORT_LABEL_EN
                    PH_LABEL: begin
                        case (lbl_q)
                            2'd0:    byte_d = 8'h50;
                            2'd1:    byte_d = sel_q ? 8'h32 : 8'h31;
                            default: byte_d = 8'h3D;
                        endcase
                        lbl_d = lbl_q + 2'd1;
                        if (lbl_q == 2'd2) begin
                            ph_d = PH_DIGIT;
                        end
                    end
`endif
                    PH_DIGIT: begin
                        byte_d  = {4'h3, w_digit};
                        first_d = 1'b0;
                        if (w_pos == 5'd0) begin
                            ph_d = PH_NL;
                        end else begin
                            dig_d = w_pos - 5'd1;
                        end
                    end
                    default: begin
                        byte_d = 8'h0A;
                    end
                endcase
                // Start bit goes out on the next cycle.
                tx_d    = 1'b0;
                bit_d   = '0;
                baud_d  = '0;
                state_d = S_TX;
            end

            S_TX: begin
                if (baud_q == C_BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        // Stop bit finished; line stays high.
                        if (byte_q == 8'h0A) begin
                            if (!sel_q) begin
                                sel_d   = 1'b1;
                                bin_d   = p2_q;
                                bcd_d   = '0;
                                iter_d  = '0;
                                state_d = S_CONV;
                            end else begin
                                state_d = S_FIN;
                            end
                        end else begin
                            state_d = S_EMIT;
                        end
                    end else begin
                        // bit_q indexes the bit now ending: 0 = start,
                        // 1..8 = data, so the next data bit is byte_q[bit_q].
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : byte_q[bit_q[2:0]];
                    end
                end else begin
                    baud_d = baud_q + C_CNT_W'(1);
                end
            end

            S_FIN: begin
                tx_d    = 1'b1;
                rdone_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            p2_q    <= '0;
            sel_q   <= 1'b0;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            ph_q    <= PH_DIGIT;
            first_q <= 1'b0;
            dig_q   <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rdone_q <= 1'b0;
`ifdef REPORT_LABEL_EN
            lbl_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            p2_q    <= p2_d;
            sel_q   <= sel_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            ph_q    <= ph_d;
            first_q <= first_d;
            dig_q   <= dig_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rdone_q <= rdone_d;
`ifdef REPORT_LABEL_EN
            lbl_q   <= lbl_d;
`endif
        end
    end

    assign uart_tx     = tx_q;
    assign busy        = busy_q;
    assign report_done = rdone_q;

endmodule
`default_nettype wire

// File: tb/tb_day04_result_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_day04_result_uart
// Description : Self-checking bench for day04_result_uart. A table of
//               {part1, part2, decimal text} records drives reports; the
//               expected ASCII bytes are queued and a UART receiver pops and
//               compares every decoded frame. Hand-written sequences cover
//               the level-held done, mid-frame reset and restart cases.
//               Honours `REPORT_LABEL_EN for the expected text.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_day04_result_uart;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] part1_result = '0;
    logic [63:0] part2_result = '0;
    logic        done = 1'b0;
    logic        uart_tx;
    logic        busy;
    logic        report_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] exp_q[$];
    bit         mon_en    = 1'b0;
    bit         have_prev = 1'b0;

    typedef struct {
        logic [63:0] p1;
        logic [63:0] p2;
        string       s1;
        string       s2;
        bit          change;
    } vec_t;

    day04_result_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .part1_result (part1_result),
        .part2_result (part2_result),
        .done         (done),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .report_done  (report_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // UART receiver: samples every cycle of a 10-bit frame at negedges.
    initial begin : mon
        logic       smp [40];
        logic [7:0] data;
        logic [7:0] prev_byte;
        logic [7:0] e;
        bit         ok;
        int         start_cyc;
        int         prev_end;
        prev_byte = '0;
        prev_end  = 0;
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                start_cyc = cyc;
                if (have_prev && prev_byte != 8'h0A) begin
                    check("byte_gap_le2", 64'((start_cyc - prev_end) <= 2), 64'd1);
                end
                for (int o = 0; o < 40; o++) begin
                    if (o > 0) @(negedge clk);
                    smp[o] = uart_tx;
                end
                ok = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 1; c < CPB; c++) begin
                        if (smp[b*CPB + c] !== smp[b*CPB]) ok = 1'b0;
                    end
                end
                if (smp[0] !== 1'b0) ok = 1'b0;
                if (smp[36] !== 1'b1) ok = 1'b0;
                for (int i = 0; i < 8; i++) data[i] = smp[(i+1)*CPB];
                check("frame_shape", 64'(ok), 64'd1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got byte 0x%02h required no byte", data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", 64'(data), 64'(e));
                end
                prev_end  = start_cyc + 40;
                prev_byte = data;
                have_prev = 1'b1;
            end
        end
    end

    task automatic run_report(input vec_t v, input bit keep_done);
        string e;
        int    n;
`ifdef REPORT_LABEL_EN
        e = {"P1=", v.s1, "\n", "P2=", v.s2, "\n"};
`else
        e = {v.s1, "\n", v.s2, "\n"};
`endif
        for (int i = 0; i < e.len(); i++) exp_q.push_back(e[i]);
        part1_result = v.p1;
        part2_result = v.p2;
        have_prev    = 1'b0;
        mon_en       = 1'b1;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        if (v.change) begin
            part1_result = 64'd99;
            part2_result = 64'd99;
        end
        check("busy_after_trigger", 64'(busy), 64'd1);
        n = 1;
        while (uart_tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("first_start_by_t67", 64'(n <= 67), 64'd1);
        n = 0;
        while (report_done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("report_done_rise", 64'(report_done), 64'd1);
        check("busy_fall_with_done", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        check("all_bytes_received", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        if (!keep_done) done = 1'b0;
    endtask

    initial begin : stim
        vec_t vecs[6];
        vec_t hv;
        int   cnt;
        int   n;

        vecs[0] = '{p1: 64'd13, p2: 64'd43, s1: "13", s2: "43", change: 1'b0};
        vecs[1] = '{p1: 64'd0, p2: 64'hFFFF_FFFF_FFFF_FFFF,
                    s1: "0", s2: "18446744073709551615", change: 1'b0};
        vecs[2] = '{p1: 64'd13, p2: 64'd43, s1: "13", s2: "43", change: 1'b1};
        vecs[3] = '{p1: 64'd7, p2: 64'd1000, s1: "7", s2: "1000", change: 1'b0};
        vecs[4] = '{p1: 64'd10000000000000000000, p2: 64'd9,
                    s1: "10000000000000000000", s2: "9", change: 1'b0};
        vecs[5] = '{p1: 64'd12345678901234567890, p2: 64'd100,
                    s1: "12345678901234567890", s2: "100", change: 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_uart_tx", 64'(uart_tx), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_report_done", 64'(report_done), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_report(vecs[i], 1'b0);
            repeat (3) @(negedge clk);
        end

        // done held high long after a report: exactly one report.
        hv = '{p1: 64'd5, p2: 64'd6, s1: "5", s2: "6", change: 1'b0};
        run_report(hv, 1'b1);
        cnt = 0;
        repeat (10000) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) cnt++;
        end
        check("held_done_no_retrigger", 64'(cnt), 64'd0);
        check("held_done_report_done", 64'(report_done), 64'd1);
        done = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of the third data bit of the first frame.
        mon_en       = 1'b0;
        part1_result = 64'd13;
        part2_result = 64'd43;
        @(negedge clk);
        done = 1'b1;
        n = 0;
        while (uart_tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_frame_started", 64'(uart_tx), 64'd0);
        repeat (13) @(negedge clk);
        rst  = 1'b1;
        done = 1'b0;
        @(negedge clk);
        check("rst_mid_frame_tx", 64'(uart_tx), 64'd1);
        check("rst_mid_frame_busy", 64'(busy), 64'd0);
        check("rst_mid_frame_report_done", 64'(report_done), 64'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) cnt++;
        end
        check("rst_no_resume", 64'(cnt), 64'd0);

        // Fresh done edge after reset starts a new report.
        run_report(vecs[0], 1'b0);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
